data_mem_responder: RTL and testbench

//  Memory-side responder for the pipelined CPU's data-memory port (initiator = MEM stage).

---
 rtl/data_mem_responder_pkg.sv | 15 +
 rtl/data_mem_responder_mem_word_array.sv | 36 +++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_responder_pkg;

  localparam int unsigned DataLen = 32;
  localparam int unsigned AddrLen = 32;
  localparam int unsigned BeWidth = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// Single-port word storage: byte-enabled synchronous write, registered synchronous read.
module data_mem_responder_mem_word_array #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 32,
  parameter int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [IdxW-1:0]      idx_i,
  input  logic [Width/8-1:0]   be_i,
  input  logic [Width-1:0]     wdata_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // One operation per enabled cycle; the read register holds between accesses.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < int'(Width / 8); i++) begin
          if (be_i[i]) begin
            mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: one transaction at a time,
// configurable access latency, range/alignment error reporting.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DepthWords = 1024,
  parameter int unsigned BaseAddr   = 0,
  parameter int unsigned WaitCycles = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_write_i,
  input  logic [AddrLen-1:0] req_addr_i,
  input  logic [DataLen-1:0] req_wdata_i,
  input  logic [BeWidth-1:0] req_be_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [DataLen-1:0] resp_rdata_o,
  output logic               resp_err_o,
  output logic               busy_o
);

  localparam int unsigned IdxW = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam logic [3:0] WaitInit = (WaitCycles == 0) ? 4'd0 : 4'(WaitCycles - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               write_q;
  logic [IdxW-1:0]    idx_q;
  logic [DataLen-1:0] wdata_q;
  logic [BeWidth-1:0] be_q;
  logic               err_q;

  logic               accept;
  logic               mem_en;
  logic [AddrLen-1:0] offset;
  logic [AddrLen-1:0] word_idx;
  logic               req_err;
  logic [DataLen-1:0] mem_rdata;

  // Addresses below the base wrap to a huge index and fail the range check.
  always_comb begin
    offset   = req_addr_i - AddrLen'(BaseAddr);
    word_idx = offset >> 2;
    req_err  = (req_addr_i[1:0] != 2'b00) || (word_idx >= AddrLen'(DepthWords));
  end

  // Next-state logic: wait countdown, single access cycle, held response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    mem_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          cnt_d   = WaitInit;
          state_d = (WaitCycles == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        mem_en  = !err_q;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and request latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write_i;
        idx_q   <= word_idx[IdxW-1:0];
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
        err_q   <= req_err;
      end
    end
  end

  data_mem_responder_mem_word_array #(
    .Depth (DepthWords),
    .Width (DataLen),
    .IdxW  (IdxW)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (mem_en),
    .we_i    (write_q),
    .idx_i   (idx_q),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Outputs decode from state; read data is gated to zero for stores and errors.
  always_comb begin
    req_ready_o  = (state_q == StIdle);
    busy_o       = (state_q != StIdle);
    resp_valid_o = (state_q == StResp);
    resp_err_o   = resp_valid_o && err_q;
    resp_rdata_o = (resp_valid_o && !err_q && !write_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench with a transaction-level reference model checked every cycle.
module tb_data_mem_responder;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Base  = 0;
  localparam int unsigned Wait  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DepthWords (Depth),
    .BaseAddr   (Base),
    .WaitCycles (Wait)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_be_i     (req_be),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .busy_o       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, result visible Wait+1 edges after accept.
  logic [31:0] m_mem [int];
  bit          m_pend = 1'b0;
  bit          m_resp = 1'b0;
  int          m_left;
  bit          m_write, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  function automatic bit addr_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    return (a % 4 != 0) || ((off / 4) >= Depth);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 1'b0;
      m_resp = 1'b0;
    end else if (!m_pend) begin
      if (req_valid) begin
        m_pend  = 1'b1;
        m_left  = Wait + 1;
        m_write = req_write;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_be    = req_be;
      end
    end else if (!m_resp) begin
      m_left--;
      if (m_left == 0) begin
        int          w;
        logic [31:0] word;
        m_err   = addr_bad(m_addr);
        w       = int'((m_addr - Base) / 4);
        m_rdata = 32'h0;
        if (!m_err) begin
          word = m_mem.exists(w) ? m_mem[w] : 32'h0;
          if (m_write) begin
            for (int b = 0; b < 4; b++) if (m_be[b]) word[8*b +: 8] = m_wdata[8*b +: 8];
            m_mem[w] = word;
          end else begin
            m_rdata = word;
          end
        end
        m_resp = 1'b1;
      end
    end else if (resp_ready) begin
      m_pend = 1'b0;
      m_resp = 1'b0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("req_ready", {31'b0, req_ready}, {31'b0, !m_pend});
      check("busy", {31'b0, busy}, {31'b0, m_pend});
      check("resp_valid", {31'b0, resp_valid}, {31'b0, m_resp});
      if (m_resp) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, m_err});
      end
    end
  end

  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
    rd = resp_rdata;
    er = resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b1;

    // 1. Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Known background contents
    txn(1'b1, 32'h20, 32'h0000_0000, 4'hF, rd, er, lat);
    txn(1'b1, 32'h00, 32'h1111_1111, 4'hF, rd, er, lat);

    // 2. Full store and read-back, with latency
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    check("st_latency", lat, 32'd4);
    check("st_err", {31'b0, er}, 32'd0);
    check("st_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_a", rd, 32'hDEAD_BEEF);
    check("ld_latency", lat, 32'd4);

    // 3. Partial store
    txn(1'b1, 32'h10, 32'h0000_1234, 4'b0011, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_b", rd, 32'hDEAD_1234);

    // 4. Errors and boundaries
    txn(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
    check("mis_err", {31'b0, er}, 32'd1);
    check("mis_rdata", rd, 32'd0);
    txn(1'b1, 4 * Depth, 32'h5555_AAAA, 4'hF, rd, er, lat);
    check("oor_err", {31'b0, er}, 32'd1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("ld0_a", rd, 32'h1111_1111);
    txn(1'b1, 4 * (Depth - 1), 32'h0BAD_CAFE, 4'hF, rd, er, lat);
    check("top_st_err", {31'b0, er}, 32'd0);
    txn(1'b0, 4 * (Depth - 1), 32'h0, 4'h0, rd, er, lat);
    check("top_ld", rd, 32'h0BAD_CAFE);
    txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
    check("be0_err", {31'b0, er}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_c", rd, 32'hDEAD_1234);

    // 5. Back-pressure with a competing request
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_valid0", {31'b0, resp_valid}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hBAD0_BAD0;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, 32'hDEAD_1234);
      check("bp_err", {31'b0, resp_err}, 32'd0);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_done", {31'b0, req_ready}, 32'd1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("ld0_b", rd, 32'h1111_1111);

    // 6. Reset aborts a store in WAIT
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_novalid", {31'b0, resp_valid}, 32'd0);
    end
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("ld20", rd, 32'h0000_0000);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
